// File: rtl/dbus_timer_if.sv
`timescale 1ns/1ps
// CPU data-bus port (M stage) into the timer register window.
// The master drives address, write data and byte enables; the slave returns read data.
interface dbus_timer_if;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata;

  modport master (
    output m_data_addr,
    output m_data_wdata,
    output m_data_byteen,
    input  m_data_rdata
  );

  modport slave (
    input  m_data_addr,
    input  m_data_wdata,
    input  m_data_byteen,
    output m_data_rdata
  );
endinterface

// File: rtl/dbus_timer.sv
`timescale 1ns/1ps
// Memory-mapped down-counter timer with CTRL/PRESET/COUNT registers.
// It supports one-shot and auto-reload modes and drives a maskable interrupt.
module dbus_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic         clk,
  input  logic         reset,
  dbus_timer_if.slave  bus,
  output logic         irq
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StCnt  = 2'd2;
  localparam logic [1:0] StInt  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pending_q, pending_d;

  logic        hit, wr, ctrl_wr, preset_wr;
  logic [1:0]  offset;
  logic        en, auto_reload, im;
  logic        fsm_clr_en, pend_set;

  assign hit         = (bus.m_data_addr[31:4] == BASE_ADDR[31:4]);
  assign offset      = bus.m_data_addr[3:2];
  assign wr          = hit && (bus.m_data_byteen != 4'b0000);
  assign ctrl_wr     = wr && (offset == 2'd0);
  assign preset_wr   = wr && (offset == 2'd1);

  assign en          = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
  assign im          = ctrl_q[3];

  logic unused_addr;
  assign unused_addr = ^bus.m_data_addr[1:0];

  always_comb begin
    bus.m_data_rdata = 32'h0;
    if (hit) begin
      case (offset)
        2'd0:    bus.m_data_rdata = {28'h0, ctrl_q};
        2'd1:    bus.m_data_rdata = preset_q;
        2'd2:    bus.m_data_rdata = count_q;
        default: bus.m_data_rdata = 32'h0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    fsm_clr_en = 1'b0;
    pend_set   = 1'b0;
    case (state_q)
      StIdle: begin
        if (en) state_d = StLoad;
      end
      StLoad: begin
        count_d = preset_q;
        state_d = StCnt;
      end
      StCnt: begin
        if (!en) begin
          state_d = StIdle;
        end else if (count_q != 32'h0) begin
          count_d = count_q - 32'h1;
        end else begin
          state_d  = StInt;
          pend_set = !auto_reload;
        end
      end
      default: begin
        if (auto_reload) begin
          state_d = StLoad;
        end else begin
          state_d    = StIdle;
          fsm_clr_en = 1'b1;
        end
      end
    endcase
  end

  // A CPU write to the EN lane overrides the FSM's one-shot EN clear.
  always_comb begin
    ctrl_d = ctrl_q;
    if (fsm_clr_en) ctrl_d[0] = 1'b0;
    if (ctrl_wr && bus.m_data_byteen[0]) ctrl_d = bus.m_data_wdata[3:0];
  end

  always_comb begin
    preset_d = preset_q;
    for (int i = 0; i < 4; i++) begin
      if (preset_wr && bus.m_data_byteen[i]) preset_d[8*i +: 8] = bus.m_data_wdata[8*i +: 8];
    end
  end

  // Any CTRL write acknowledges the interrupt, even on the edge it is raised.
  always_comb begin
    pending_d = pending_q;
    if (pend_set) pending_d = 1'b1;
    if (ctrl_wr)  pending_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      ctrl_q    <= 4'h0;
      preset_q  <= 32'h0;
      count_q   <= 32'h0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  assign irq = im && (pending_q || ((state_q == StInt) && auto_reload));

endmodule

// File: tb/tb_dbus_timer.sv
`timescale 1ns/1ps
// Directed bench for dbus_timer: each task drives one scenario and checks inline.
module tb_dbus_timer;
  localparam logic [31:0] Base = 32'h0000_7F00;
  localparam logic [31:0] ACtrl = Base + 32'h0;
  localparam logic [31:0] APre  = Base + 32'h4;
  localparam logic [31:0] ACnt  = Base + 32'h8;
  localparam logic [31:0] ARes  = Base + 32'hC;

  logic clk;
  logic reset;
  logic irq;
  int   checks;
  int   errors;

  dbus_timer_if bus ();

  dbus_timer #(.BASE_ADDR(Base)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.m_data_addr   = a;
    bus.m_data_wdata  = d;
    bus.m_data_byteen = be;
    tick();
    bus.m_data_byteen = 4'b0000;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.m_data_addr = a;
    #1;
    d = bus.m_data_rdata;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    wr(APre, 32'hDEAD_BEEF, 4'hF);
    wr(ACtrl, 32'hF, 4'hF);
    reset = 1'b1;
    bus.m_data_addr   = ACtrl;
    bus.m_data_wdata  = 32'h9;
    bus.m_data_byteen = 4'hF;
    tick();
    bus.m_data_byteen = 4'h0;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(Base + 32'(4 * i), v);
      checks++;
      if (v !== 32'h0) begin
        errors++;
        $display("FAIL reset_off%0d got %h want %h", i, v, 32'h0);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got %b want 0", irq);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    logic [31:0] exp_cnt [4] = '{32'd3, 32'd2, 32'd1, 32'd0};
    do_reset();
    wr(APre, 32'd3, 4'hF);
    wr(ACtrl, 32'h9, 4'hF);  // edge T
    tick();                  // T+1: LOAD
    rd(ACnt, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL os_load_cnt got %h want 0", v); end
    for (int k = 0; k < 4; k++) begin
      tick();                // T+2..T+5
      rd(ACnt, v);
      checks++;
      if (v !== exp_cnt[k] || irq !== 1'b0) begin
        errors++;
        $display("FAIL os_cnt%0d got %h irq %b want %h irq 0", k, v, irq, exp_cnt[k]);
      end
    end
    tick();                  // T+6: INT
    rd(ACtrl, v);
    checks++;
    if (irq !== 1'b1 || v !== 32'h9) begin
      errors++;
      $display("FAIL os_int got irq %b ctrl %h want irq 1 ctrl 9", irq, v);
    end
    tick();                  // T+7: EN cleared
    rd(ACtrl, v);
    checks++;
    if (v !== 32'h8) begin errors++; $display("FAIL os_en_clr got %h want 8", v); end
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL os_irq_hold got %b want 1", irq); end
    wr(ACtrl, 32'h8, 4'h1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL os_irq_ack got %b want 0", irq); end
  endtask

  task automatic test_autoreload();
    logic [31:0] v;
    logic        exp_irq;
    do_reset();
    wr(APre, 32'd2, 4'hF);
    wr(ACtrl, 32'hB, 4'hF);  // edge T
    for (int k = 1; k <= 15; k++) begin
      tick();
      exp_irq = (k >= 5) && ((k % 5) == 0);
      checks++;
      if (irq !== exp_irq) begin
        errors++;
        $display("FAIL ar_irq_k%0d got %b want %b", k, irq, exp_irq);
      end
      if (k >= 2 && ((k - 2) % 5) < 3) begin
        rd(ACnt, v);
        checks++;
        if (v !== 32'(2 - ((k - 2) % 5))) begin
          errors++;
          $display("FAIL ar_cnt_k%0d got %h want %h", k, v, 32'(2 - ((k - 2) % 5)));
        end
      end
    end
  endtask

  task automatic test_masked();
    logic [31:0] v;
    int          highs;
    do_reset();
    wr(APre, 32'd1, 4'hF);
    wr(ACtrl, 32'h1, 4'hF);
    highs = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (irq !== 1'b0) highs++;
    end
    checks++;
    if (highs != 0) begin errors++; $display("FAIL mask_irq got %0d high cycles want 0", highs); end
    rd(ACtrl, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL mask_en_clr got %h want 0", v); end
    wr(ACtrl, 32'h8, 4'hF);
    tick();
    rd(ACtrl, v);
    checks++;
    if (v !== 32'h8 || irq !== 1'b0) begin
      errors++;
      $display("FAIL mask_ack got ctrl %h irq %b want ctrl 8 irq 0", v, irq);
    end
  endtask

  task automatic test_bytelanes();
    logic [31:0] v;
    do_reset();
    wr(APre, 32'h1111_1111, 4'hF);
    wr(APre, 32'h0000_AB00, 4'b0010);
    rd(APre, v);
    checks++;
    if (v !== 32'h1111_AB11) begin errors++; $display("FAIL lane_pre got %h want 1111ab11", v); end
    wr(ACnt, 32'hFFFF_FFFF, 4'hF);
    rd(ACnt, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL cnt_ro got %h want 0", v); end
    wr(ARes, 32'hFFFF_FFFF, 4'hF);
    rd(ARes, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL res_rd got %h want 0", v); end
    wr(Base + 32'h10, 32'hFFFF_FFFF, 4'hF);
    rd(Base + 32'h10, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL miss_rd got %h want 0", v); end
    rd(APre, v);
    checks++;
    if (v !== 32'h1111_AB11) begin errors++; $display("FAIL miss_pre got %h want 1111ab11", v); end
    rd(ACtrl, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL miss_ctrl got %h want 0", v); end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] v;
    do_reset();
    wr(APre, 32'd10, 4'hF);
    wr(ACtrl, 32'h9, 4'hF);  // edge T
    tick();
    tick();                  // T+2
    rd(ACnt, v);
    checks++;
    if (v !== 32'd10) begin errors++; $display("FAIL mc_cnt10 got %h want a", v); end
    wr(APre, 32'd2, 4'hF);   // T+3: preset change must not disturb count
    rd(ACnt, v);
    checks++;
    if (v !== 32'd9) begin errors++; $display("FAIL mc_pre_iso got %h want 9", v); end
    for (int k = 0; k < 4; k++) tick();
    rd(ACnt, v);
    checks++;
    if (v !== 32'd5) begin errors++; $display("FAIL mc_cnt5 got %h want 5", v); end
    reset = 1'b1;
    bus.m_data_addr   = ACtrl;
    bus.m_data_wdata  = 32'hF;
    bus.m_data_byteen = 4'hF;
    tick();
    bus.m_data_byteen = 4'h0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd(Base + 32'(4 * i), v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL mc_rst_off%0d got %h want 0", i, v); end
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL mc_rst_irq got %b want 0", irq); end
    tick();
    tick();
    rd(ACnt, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL mc_idle_cnt got %h want 0", v); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    do_reset();
    wr(APre, 32'd0, 4'hF);
    wr(ACtrl, 32'h9, 4'hF);  // edge T
    tick();
    tick();
    tick();                  // T+3: INT
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL b2b_int got %b want 1", irq); end
    wr(ACtrl, 32'h9, 4'hF);  // lands on the INT edge
    rd(ACtrl, v);
    checks++;
    if (v !== 32'h9 || irq !== 1'b0) begin
      errors++;
      $display("FAIL b2b_win got ctrl %h irq %b want ctrl 9 irq 0", v, irq);
    end
    tick();
    tick();                  // LOAD, then CNT at 0
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL b2b_cnt got %b want 0", irq); end
    tick();                  // INT again
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL b2b_restart got %b want 1", irq); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.m_data_addr   = 32'h0;
    bus.m_data_wdata  = 32'h0;
    bus.m_data_byteen = 4'h0;
    tick();
    tick();
    reset = 1'b0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_masked();
    test_bytelanes();
    test_reset_midcount();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dbus_timer.md
DBUS_TIMER -- requirements
Module: dbus_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_7F00, word-aligned base of a 16-byte register window.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port m_data_addr, input, 32: CPU data-bus byte address (M stage).
REQ-005 SHALL have port m_data_wdata, input, 32: write data, lane-aligned.
REQ-006 SHALL have port m_data_byteen, input, 4: per-byte write enables; 4'b0000 means no write.
REQ-007 SHALL have port m_data_rdata, output, 32: combinational read data for m_data_addr.
REQ-008 SHALL have port irq, output, 1: interrupt request to CPU.

Function
REQ-009 SHALL decode a hit when m_data_addr[31:4] == BASE_ADDR[31:4]; offset = m_data_addr[3:2].
REQ-010 SHALL map offset 0 to CTRL (R/W), offset 1 to PRESET (R/W), offset 2 to COUNT (read-only), offset 3 to reserved (reads 0, writes ignored).
REQ-011 SHALL define CTRL[0] EN, CTRL[2:1] MODE (00 one-shot, 01 auto-reload, 10/11 behave as 00), CTRL[3] IM; CTRL[31:4] read as 0.
REQ-012 SHALL return on m_data_rdata the addressed register when hit, else 32'h0; no cycle latency.
REQ-013 SHALL write each byte lane i of the addressed R/W register where m_data_byteen[i]=1 and hit; other lanes hold.
REQ-014 SHALL ignore writes to COUNT and reserved offset; never alter state on a miss.
REQ-015 SHALL implement FSM states IDLE, LOAD, CNT, INT.
REQ-016 IDLE: EN=1 -> LOAD; else stay; COUNT holds.
REQ-017 LOAD: COUNT <= PRESET; -> CNT.
REQ-018 CNT: EN=0 -> IDLE, COUNT holds; else COUNT!=0 -> COUNT-1, stay; COUNT==0 -> INT.
REQ-019 CNT->INT edge SHALL set PENDING when MODE!=01.
REQ-020 INT, MODE!=01: clear CTRL.EN, -> IDLE. INT, MODE=01: -> LOAD, EN unchanged.
REQ-021 irq SHALL equal IM & (PENDING | (state==INT & MODE==01)); auto-reload gives one-cycle pulse, one-shot holds level.
REQ-022 Any CPU write hitting CTRL (any lane) SHALL clear PENDING on that edge.
REQ-023 Same-edge CPU CTRL write and FSM EN clear (INT state): CPU-written value SHALL win.
REQ-024 PRESET writes mid-count SHALL not affect COUNT until next LOAD.
REQ-025 PRESET=0: LOAD, one CNT cycle at 0, then INT.
REQ-026 Auto-reload period SHALL be PRESET+3 cycles (LOAD 1, CNT PRESET+1, INT 1).
REQ-027 COUNT SHALL be 32-bit unsigned; no underflow wrap (INT taken at 0).

Reset
REQ-028 On reset=1 at a rising edge: CTRL, PRESET, COUNT, PENDING <= 0; state <= IDLE; irq low next cycle.
REQ-029 Reset SHALL override simultaneous CPU writes and abort any state mid-count.
REQ-030 m_data_rdata SHALL read 0 from all offsets after reset.

Verification
REQ-031 Write PRESET=3, then CTRL=32'h9 (EN,IM,one-shot) at edge T -> LOAD at T+1, COUNT=3 at T+2, COUNT 2,1,0 at T+3..T+5, irq high after T+6, EN reads 0 after T+7, irq stays high until CTRL written.
REQ-032 PRESET=2, CTRL=32'hB (auto-reload, IM) -> irq one-cycle pulses every 5 cycles, COUNT cycles 2,1,0.
REQ-033 One-shot with IM=0 -> irq never rises; PENDING set; later write CTRL=32'h8 -> PENDING cleared, irq stays low.
REQ-034 Byteen=4'b0010, wdata=32'h0000_AB00 to PRESET=32'h1111_1111 -> PRESET reads 32'h1111_AB11; write to COUNT and to address BASE+16 -> no change, miss reads 0.
REQ-035 Assert reset during CNT with COUNT=5 -> all registers 0, IDLE, irq 0 next cycle.
REQ-036 CPU writes CTRL=32'h9 on the same edge FSM is in INT (one-shot) -> CTRL reads 32'h9, PENDING 0, FSM restarts via IDLE->LOAD.
